// File: rtl/motor_seq_pkg.sv
// Shared types for the motor sequencer: state encoding, default durations,
// and the fixed-priority decode of navigation request levels.
package motor_seq_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        FWD      = 3'd1,
        TURN     = 3'd2,
        ARC      = 3'd3,
        ARM_EXT  = 3'd4,
        ARM_HOLD = 3'd5,
        ARM_RET  = 3'd6,
        HALT     = 3'd7
    } state_t;

    localparam int DEF_FWD_CYCLES  = 8;
    localparam int DEF_TURN_CYCLES = 12;
    localparam int DEF_ARM_CYCLES  = 6;
    localparam int DEF_HOLD_CYCLES = 4;

    function automatic int max4(input int a, input int b, input int c, input int d);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return m;
    endfunction

    // under > remover > both moves (arc) > girar > avancar
    function automatic state_t req_decode(input logic under, input logic remover,
                                          input logic avancar, input logic girar);
        if (under)                  return HALT;
        else if (remover)           return ARM_EXT;
        else if (avancar && girar)  return ARC;
        else if (girar)             return TURN;
        else if (avancar)           return FWD;
        else                        return IDLE;
    endfunction

endpackage

// File: rtl/seq_timer.sv
// Loadable down-counter shared by every timed sequencer state; load wins,
// otherwise counts down one per cycle and rests at zero.
module seq_timer #(
    parameter int W = 4
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_load,
    input  logic [W-1:0] i_load_val,
    output logic [W-1:0] o_value,
    output logic         o_zero
);

    logic [W-1:0] r_cnt;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n)
            r_cnt <= '0;
        else if (i_load)
            r_cnt <= i_load_val;
        else if (r_cnt != '0)
            r_cnt <= r_cnt - W'(1);
    end

    assign o_value = r_cnt;
    assign o_zero  = (r_cnt == '0);

endmodule

// File: rtl/motor_sequencer.sv
// Turns one-cycle nav requests into timed motor/arm sequences; request at edge t drives actuators t+1..t+N, done at t+N+1.
// Requests while busy are dropped, not queued. Optional odometry counter: MOTOR_SEQ_ODOMETRY_EN.
module motor_sequencer
    import motor_seq_pkg::*;
#(
    parameter int FWD_CYCLES  = DEF_FWD_CYCLES,
    parameter int TURN_CYCLES = DEF_TURN_CYCLES,
    parameter int ARM_CYCLES  = DEF_ARM_CYCLES,
    parameter int HOLD_CYCLES = DEF_HOLD_CYCLES
) (
    input  logic        c1,
    input  logic        reset,
    input  logic        avancar,
    input  logic        girar,
    input  logic        remover,
    input  logic        under,
    output logic        motor_l,
    output logic        motor_r,
    output logic        dir_r,
    output logic        arm_ext,
    output logic        arm_ret,
    output logic        cmd_ack,
    output logic        done,
    output logic        busy,
    output logic        halted,
    output logic [15:0] step_count
);

    localparam int CW = $clog2(max4(FWD_CYCLES, TURN_CYCLES, ARM_CYCLES, HOLD_CYCLES)) + 1;
    localparam logic [CW-1:0] L_FWD  = CW'(FWD_CYCLES - 1);
    localparam logic [CW-1:0] L_TURN = CW'(TURN_CYCLES - 1);
    localparam logic [CW-1:0] L_ARM  = CW'(ARM_CYCLES - 1);
    localparam logic [CW-1:0] L_HOLD = CW'(HOLD_CYCLES - 1);

    state_t          r_state;
    state_t          w_nxt;
    logic            w_load;
    logic            w_done_nxt;
    logic [CW-1:0]   w_load_val;
    logic [CW-1:0]   w_cnt;
    logic            w_zero;
    logic            w_arm_seq;
    logic            w_ret_nxt;
    logic            r_motor_l, r_motor_r, r_dir_r, r_arm_ext, r_arm_ret;
    logic            r_cmd_ack, r_done, r_busy, r_halted;

    seq_timer #(.W(CW)) u_timer (
        .i_clk      (c1),
        .i_rst_n    (reset),
        .i_load     (w_load),
        .i_load_val (w_load_val),
        .o_value    (w_cnt),
        .o_zero     (w_zero)
    );

    assign w_arm_seq = (r_state == ARM_EXT) || (r_state == ARM_HOLD) || (r_state == ARM_RET);

    always_comb begin
        w_nxt      = r_state;
        w_load     = 1'b0;
        w_load_val = '0;
        w_done_nxt = 1'b0;
        if (under) begin
            w_nxt = HALT;
            // re-asserting under inside HALT must not restart the retract
            if (r_state != HALT) begin
                w_load     = 1'b1;
                w_load_val = w_arm_seq ? L_ARM : '0;
            end
        end else begin
            case (r_state)
                IDLE: begin
                    w_nxt  = req_decode(1'b0, remover, avancar, girar);
                    w_load = (w_nxt != IDLE);
                    case (w_nxt)
                        FWD, ARC: w_load_val = L_FWD;
                        TURN:     w_load_val = L_TURN;
                        ARM_EXT:  w_load_val = L_ARM;
                        default:  w_load_val = '0;
                    endcase
                end
                FWD, TURN, ARC, ARM_RET: begin
                    if (w_zero) begin
                        w_nxt      = IDLE;
                        w_done_nxt = 1'b1;
                    end
                end
                ARM_EXT: begin
                    if (w_zero) begin
                        w_nxt      = ARM_HOLD;
                        w_load     = 1'b1;
                        w_load_val = L_HOLD;
                    end
                end
                ARM_HOLD: begin
                    if (w_zero) begin
                        w_nxt      = ARM_RET;
                        w_load     = 1'b1;
                        w_load_val = L_ARM;
                    end
                end
                HALT: begin
                    if (w_zero) w_nxt = IDLE;
                end
                default: w_nxt = IDLE;
            endcase
        end
    end

    // HALT keeps retracting only while the counter loaded on entry is still running
    assign w_ret_nxt = (w_nxt == ARM_RET) ||
                       ((w_nxt == HALT) && ((r_state == HALT) ? (r_arm_ret && (w_cnt != '0))
                                                              : w_arm_seq));

    always_ff @(posedge c1) begin
        if (!reset) begin
            r_state   <= IDLE;
            r_motor_l <= 1'b0;
            r_motor_r <= 1'b0;
            r_dir_r   <= 1'b0;
            r_arm_ext <= 1'b0;
            r_arm_ret <= 1'b0;
            r_cmd_ack <= 1'b0;
            r_done    <= 1'b0;
            r_busy    <= 1'b0;
            r_halted  <= 1'b0;
        end else begin
            r_state   <= w_nxt;
            r_motor_l <= (w_nxt == FWD) || (w_nxt == TURN) || (w_nxt == ARC);
            r_motor_r <= (w_nxt == FWD) || (w_nxt == TURN);
            r_dir_r   <= (w_nxt == TURN);
            r_arm_ext <= (w_nxt == ARM_EXT);
            r_arm_ret <= w_ret_nxt;
            r_cmd_ack <= (r_state == IDLE) && (w_nxt != IDLE) && (w_nxt != HALT);
            r_done    <= w_done_nxt;
            r_busy    <= (w_nxt != IDLE);
            r_halted  <= (w_nxt == HALT);
        end
    end

`ifdef MOTOR_SEQ_ODOMETRY_EN
    logic [15:0] r_step_count;

    always_ff @(posedge c1) begin
        if (!reset)
            r_step_count <= 16'h0000;
        else if (w_done_nxt && ((r_state == FWD) || (r_state == ARC)))
            r_step_count <= r_step_count + 16'd1;
    end

    assign step_count = r_step_count;
`else
    assign step_count = 16'h0000;
`endif

    assign motor_l = r_motor_l;
    assign motor_r = r_motor_r;
    assign dir_r   = r_dir_r;
    assign arm_ext = r_arm_ext;
    assign arm_ret = r_arm_ret;
    assign cmd_ack = r_cmd_ack;
    assign done    = r_done;
    assign busy    = r_busy;
    assign halted  = r_halted;

endmodule

// File: tb/tb_motor_sequencer.sv
// Bench for motor_sequencer: directed scenarios then random requests, compared every cycle
// against a schedule-queue model of the actuator timeline.
module tb_motor_sequencer;

    localparam int NF = 8;
    localparam int NT = 12;
    localparam int NA = 6;
    localparam int NH = 4;
`ifdef MOTOR_SEQ_ODOMETRY_EN
    localparam bit ODO = 1'b1;
`else
    localparam bit ODO = 1'b0;
`endif

    logic        c1 = 1'b0;
    logic        reset, avancar, girar, remover, under;
    logic        motor_l, motor_r, dir_r, arm_ext, arm_ret;
    logic        cmd_ack, done, busy, halted;
    logic [15:0] step_count;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc_n    = 0;

    // model state: queue of {motor_l, motor_r, dir_r, arm_ext, arm_ret} per cycle
    logic [4:0]  sched[$];
    bit          running, in_halt, arm_seq, is_step;
    int          ret_left;
    logic [15:0] steps;
    logic [4:0]  e_act;
    logic        e_ack, e_done, e_busy, e_halted;

    always #5 c1 = ~c1;

    motor_sequencer #(
        .FWD_CYCLES (NF),
        .TURN_CYCLES(NT),
        .ARM_CYCLES (NA),
        .HOLD_CYCLES(NH)
    ) dut (
        .c1(c1), .reset(reset), .avancar(avancar), .girar(girar), .remover(remover),
        .under(under), .motor_l(motor_l), .motor_r(motor_r), .dir_r(dir_r),
        .arm_ext(arm_ext), .arm_ret(arm_ret), .cmd_ack(cmd_ack), .done(done),
        .busy(busy), .halted(halted), .step_count(step_count)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s cycle=%0d got=%h expected=%h", tag, cyc_n, obs, exp);
        end
    endtask

    task automatic push_n(input int n, input logic [4:0] pat);
        for (int k = 0; k < n; k++) sched.push_back(pat);
    endtask

    // Advances the model by one clock edge using the inputs sampled at that edge.
    task automatic model_step();
        logic [4:0] act;
        act    = 5'b0;
        e_ack  = 1'b0;
        e_done = 1'b0;
        if (!reset) begin
            sched.delete();
            running = 0; in_halt = 0; arm_seq = 0; is_step = 0; ret_left = 0; steps = 16'h0;
        end else if (under) begin
            if (!in_halt) begin
                ret_left = (running && arm_seq) ? NA : 0;
                in_halt  = 1;
                running  = 0;
                sched.delete();
            end
            if (ret_left > 0) begin act[0] = 1'b1; ret_left--; end
        end else if (in_halt) begin
            if (ret_left > 0) begin act[0] = 1'b1; ret_left--; end
            else in_halt = 0;
        end else if (running) begin
            if (sched.size() == 0) begin
                running = 0;
                e_done  = 1'b1;
                if (is_step) steps = steps + 16'd1;
            end else begin
                act = sched.pop_front();
            end
        end else if (remover || avancar || girar) begin
            arm_seq = 0; is_step = 0;
            if (remover) begin
                push_n(NA, 5'b00010); push_n(NH, 5'b00000); push_n(NA, 5'b00001);
                arm_seq = 1;
            end else if (avancar && girar) begin
                push_n(NF, 5'b10000); is_step = 1;
            end else if (girar) begin
                push_n(NT, 5'b11100);
            end else begin
                push_n(NF, 5'b11000); is_step = 1;
            end
            act     = sched.pop_front();
            e_ack   = 1'b1;
            running = 1;
        end
        e_act    = act;
        e_busy   = running || in_halt;
        e_halted = in_halt;
    endtask

    task automatic cyc(input logic r, input logic av, input logic gi, input logic rm, input logic un);
        reset = r; avancar = av; girar = gi; remover = rm; under = un;
        @(posedge c1);
        model_step();
        @(negedge c1);
        cyc_n++;
        check("outputs",
              {23'd0, motor_l, motor_r, dir_r, arm_ext, arm_ret, cmd_ack, done, busy, halted},
              {23'd0, e_act, e_ack, e_done, e_busy, e_halted});
        check("step_count", {16'd0, step_count}, {16'd0, (ODO ? steps : 16'h0000)});
    endtask

    task automatic idle(input int n);
        repeat (n) cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    int uhold;

    initial begin
        reset = 1'b0; avancar = 1'b0; girar = 1'b0; remover = 1'b0; under = 1'b0;
        uhold = 0;

        repeat (3) cyc(1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
        check("reset_outputs",
              {22'd0, motor_l, motor_r, dir_r, arm_ext, arm_ret, cmd_ack, done, busy, halted,
               (step_count != 16'h0)}, 32'd0);

        // forward step, then arc with an ignored mid-sequence avancar
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0); idle(10);
        cyc(1'b1, 1'b1, 1'b1, 1'b0, 1'b0); idle(3);
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0); idle(8);

        // full arm cycle, then one aborted on its third extend cycle
        cyc(1'b1, 1'b0, 1'b0, 1'b1, 1'b0); idle(20);
        cyc(1'b1, 1'b0, 1'b0, 1'b1, 1'b0); idle(2);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        repeat (2) cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
        idle(10);

        // reset mid-turn, then a normal forward step
        cyc(1'b1, 1'b0, 1'b1, 1'b0, 1'b0); idle(4);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0); idle(1);
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0); idle(10);

        // odometry: three steps, a turn, and a step aborted by under
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        repeat (3) begin cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0); idle(9); end
        cyc(1'b1, 1'b0, 1'b1, 1'b0, 1'b0); idle(13);
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0); idle(3);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b1); idle(3);
        check("odometry_plan", {16'd0, step_count}, ODO ? 32'd3 : 32'd0);

        for (int i = 0; i < 4000; i++) begin
            logic r, a, g, m;
            if (uhold > 0) uhold--;
            else if ($urandom_range(0, 59) == 0) uhold = $urandom_range(1, 12);
            r = ($urandom_range(0, 399) != 0);
            a = ($urandom_range(0, 3) == 0);
            g = ($urandom_range(0, 3) == 0);
            m = ($urandom_range(0, 7) == 0);
            cyc(r, a, g, m, (uhold > 0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/motor_sequencer.md
Name: motor_sequencer

Overview:
- Sequences the robot's drive motors and debris arm from the one-cycle command levels produced by the navigation FSM (avancar, girar, remover).
- Converts each accepted command into a timed actuator sequence: forward step, in-place turn, arc step, or arm extend/hold/retract.
- Arbitrates simultaneous requests by fixed priority and forces an emergency halt when the under sensor fires.
- Sits between the navigation FSM and the motor/arm drivers; all outputs are registered.

Parameters:
- FWD_CYCLES, 8, cycles the motors are driven for one forward step (>=1)
- TURN_CYCLES, 12, cycles for one in-place turn (>=1)
- ARM_CYCLES, 6, cycles for arm extend, and again for arm retract (>=1)
- HOLD_CYCLES, 4, cycles the arm is held extended (>=1)

Ports:
- c1  in  1  system clock; all logic on the rising edge
- reset  in  1  synchronous, active-low reset
- avancar  in  1  forward request from the navigation FSM
- girar  in  1  turn request from the navigation FSM
- remover  in  1  debris-removal request
- under  in  1  floor/drop sensor; 1 = emergency
- motor_l  out  1  left wheel drive enable
- motor_r  out  1  right wheel drive enable
- dir_r  out  1  right wheel direction (1 = reverse)
- arm_ext  out  1  arm extend drive
- arm_ret  out  1  arm retract drive
- cmd_ack  out  1  one-cycle pulse when a command is accepted
- done  out  1  one-cycle pulse when a sequence completes
- busy  out  1  high whenever state != IDLE
- halted  out  1  high while in HALT
- step_count  out  16  forward-step odometry (see Optional Feature)

Behaviour:
- Clock and reset: one clock, c1. reset is synchronous and active-low.
- Reset (reset==0 at a c1 edge):
  - state=IDLE, counter=0.
  - All outputs 0, including step_count.
  - Reset overrides everything, including mid-sequence and HALT; the arm is not auto-retracted on reset.
- States: IDLE, FWD, TURN, ARC, ARM_EXT, ARM_HOLD, ARM_RET, HALT. Encoding lives in the package.
- Command sampling:
  - Requests are sampled only in IDLE. Requests presented while busy are ignored, not queued.
  - Priority: under > remover > (avancar&girar -> ARC) > girar -> TURN > avancar -> FWD.
- Entry to a sequence state:
  - The down-counter is loaded with (duration-1).
  - cmd_ack=1 for exactly that first cycle in the new state.
- Counter behaviour: the counter decrements every cycle in a timed state. When counter==0, the next state is taken and the counter is reloaded for that state.
- Actuator levels per state:
  - FWD: motor_l=1, motor_r=1, dir_r=0.
  - TURN: motor_l=1, motor_r=1, dir_r=1 (spin in place).
  - ARC: motor_l=1, motor_r=0, for FWD_CYCLES.
  - ARM_EXT: arm_ext=1 for ARM_CYCLES, then ARM_HOLD.
  - ARM_HOLD: no drives, HOLD_CYCLES, then ARM_RET.
  - ARM_RET: arm_ret=1 for ARM_CYCLES.
  - Motors are 0 in all arm states.
- Completion:
  - The last cycle of FWD/TURN/ARC/ARM_RET transitions to IDLE.
  - done=1 in that first IDLE cycle.
  - A new command may be sampled in that same cycle, so the minimum gap between sequences is 1 idle cycle.
- Latency:
  - Request in IDLE at edge t -> actuators active from t+1 for exactly N cycles.
  - done at t+N+1.
- Emergency (under==1 at any edge, in any non-reset state):
  - Next state is HALT; motors drop to 0 on the next cycle.
  - If the arm had left IDLE this sequence (ARM_EXT/HOLD/RET), HALT drives arm_ret=1 for ARM_CYCLES; otherwise arm_ret=0.
  - No done pulse is generated for the aborted sequence.
- HALT exit:
  - halted=1 throughout HALT.
  - Exit to IDLE only when under==0 and the retract counter has expired; done is not pulsed.
  - under re-asserting during HALT restarts nothing and keeps HALT.
- Width rule: counter width = $clog2(max of all durations)+1 bits.

Optional Feature:
- Macro: MOTOR_SEQ_ODOMETRY_EN.
- Defined: step_count increments by 1, wrapping modulo 2^16, on each completed FWD or ARC sequence (the cycle done is asserted). Aborted or HALTed steps do not count. Cleared by reset.
- Undefined: step_count is tied to 16'h0000 and no counter register is built.

Decomposition:
- Package motor_seq_pkg holds:
  - the state enum typedef (3 bits);
  - default duration constants;
  - the priority encoding of request vectors.
- One sub-module, seq_timer: a loadable down-counter with load, value, and zero flag. It is instantiated once and shared by all timed states.

Test Plan:
- Reset then avancar=1 for one cycle -> cmd_ack at t+1; motor_l=motor_r=1 for cycles t+1..t+8; done at t+9; busy low at t+9.
- avancar=1 and girar=1 together -> ARC: motor_l=1, motor_r=0 for 8 cycles, one done pulse; a second avancar during ARC is ignored (no second cmd_ack).
- remover=1 -> arm_ext 6 cycles, hold 4 cycles, arm_ret 6 cycles; done at t+17; motors 0 throughout.
- under=1 on the 3rd cycle of ARM_EXT -> HALT next cycle, halted=1, arm_ret=1 for 6 cycles, no done; under dropped -> IDLE.
- reset=0 asserted mid-TURN -> all outputs 0 at the next edge, state IDLE; a later avancar is accepted normally.
- With MOTOR_SEQ_ODOMETRY_EN: 3 FWD steps + 1 TURN + 1 FWD aborted by under -> step_count=3. Without the macro -> step_count stays 0.
